// File: rtl/fpmul_arb_pkg.sv
// Shared types and the arbitration picker for fpmul_arbiter.
// The picker works on a 16-lane padded vector so one function serves every NUM_REQ.
package fpmul_arb_pkg;

    localparam int FP16_W  = 16;
    localparam int MAX_REQ = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    // First valid index strictly after 'last', wrapping; 'last' itself is tried last.
    // Unused lanes are zero in 'valid', so wrapping at 16 equals wrapping at NUM_REQ.
    function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                           input logic [3:0]         last);
        logic [3:0] idx;
        logic [3:0] pick;
        logic       found;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= MAX_REQ; i++) begin
            idx = last + 4'(i);
            if (!found && valid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/FPMUL.sv
// Combinational FP16 multiplier, round-to-nearest-even.
// Subnormal operands/results flush to signed zero; NaN results are canonical 16'h7E00.
module FPMUL (
    input  logic [15:0] opA_i,
    input  logic [15:0] opB_i,
    output logic [15:0] MUL_o
);

    logic              sign;
    logic [4:0]        ea, eb;
    logic [9:0]        ma, mb;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [21:0]       prod;
    logic [9:0]        frac;
    logic              guard, sticky;
    logic [10:0]       frac_rnd;
    logic signed [7:0] exp_r;

    assign sign   = opA_i[15] ^ opB_i[15];
    assign ea     = opA_i[14:10];
    assign eb     = opB_i[14:10];
    assign ma     = opA_i[9:0];
    assign mb     = opB_i[9:0];
    assign a_nan  = (ea == 5'h1F) && (ma != 10'h0);
    assign b_nan  = (eb == 5'h1F) && (mb != 10'h0);
    assign a_inf  = (ea == 5'h1F) && (ma == 10'h0);
    assign b_inf  = (eb == 5'h1F) && (mb == 10'h0);
    assign a_zero = (ea == 5'h00);
    assign b_zero = (eb == 5'h00);

    always_comb begin
        prod  = 22'({1'b1, ma}) * 22'({1'b1, mb});
        exp_r = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 8'sd15;
        if (prod[21]) begin
            frac   = prod[20:11];
            guard  = prod[10];
            sticky = |prod[9:0];
            exp_r  = exp_r + 8'sd1;
        end else begin
            frac   = prod[19:10];
            guard  = prod[9];
            sticky = |prod[8:0];
        end
        frac_rnd = {1'b0, frac} + 11'(guard & (sticky | frac[0]));
        // Rounding carry-out leaves the fraction at zero and bumps the exponent.
        if (frac_rnd[10]) begin
            exp_r = exp_r + 8'sd1;
        end

        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            MUL_o = 16'h7E00;
        end else if (a_inf || b_inf) begin
            MUL_o = {sign, 5'h1F, 10'h000};
        end else if (a_zero || b_zero) begin
            MUL_o = {sign, 15'h0000};
        end else if (exp_r >= 8'sd31) begin
            MUL_o = {sign, 5'h1F, 10'h000};
        end else if (exp_r <= 8'sd0) begin
            MUL_o = {sign, 15'h0000};
        end else begin
            MUL_o = {sign, exp_r[4:0], frac_rnd[9:0]};
        end
    end

endmodule

// File: rtl/fpmul_arbiter.sv
// Shares one FP16 multiplier among NUM_REQ requesters; FPMUL_ARB_RR_EN selects round-robin, else fixed priority.
// Latency: product visible one cycle after accept; one product per cycle while resp_ready_i is high.
// Backpressure: a full result register with resp_ready_i low grants nobody and holds data/ID stable.
module fpmul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    input  logic [16*NUM_REQ-1:0] req_opA_i,
    input  logic [16*NUM_REQ-1:0] req_opB_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    output logic                  resp_valid_o,
    output logic [15:0]           resp_data_o,
    output logic [ID_W-1:0]       resp_id_o,
    input  logic                  resp_ready_i
);
    import fpmul_arb_pkg::*;

    state_e            state_q, state_d;
    logic              can_accept, any_valid, grant_en, accept;
    logic [MAX_REQ-1:0] valid_pad;
    logic [3:0]        last_pad;
    logic [ID_W-1:0]   grant_idx;
    logic [FP16_W-1:0] op_a, op_b, mul_res;
    logic [FP16_W-1:0] data_q;
    logic [ID_W-1:0]   id_q;

    assign can_accept = (state_q == EMPTY) || resp_ready_i;
    assign any_valid  = |req_valid_i;
    assign grant_en   = can_accept && any_valid && !rst_i;

`ifdef FPMUL_ARB_RR_EN
    logic [ID_W-1:0] last_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= ID_W'(NUM_REQ - 1);
        end else if (accept) begin
            last_q <= grant_idx;
        end
    end

    always_comb begin
        last_pad              = '0;
        last_pad[ID_W-1:0]    = last_q;
    end
`else
    // Pretending the last winner was lane 15 makes the search start at lane 0.
    assign last_pad = 4'hF;
`endif

    always_comb begin
        valid_pad                = '0;
        valid_pad[NUM_REQ-1:0]   = req_valid_i;
    end

    assign grant_idx = ID_W'(rr_pick(valid_pad, last_pad));

    always_comb begin
        req_ready_o = '0;
        if (grant_en) begin
            req_ready_o[grant_idx] = 1'b1;
        end
    end

    assign accept = |(req_valid_i & req_ready_o);
    assign op_a   = req_opA_i[FP16_W*grant_idx +: FP16_W];
    assign op_b   = req_opB_i[FP16_W*grant_idx +: FP16_W];

    FPMUL u_fpmul (
        .opA_i (op_a),
        .opB_i (op_b),
        .MUL_o (mul_res)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (accept) state_d = FULL;
            FULL:    if (!accept && resp_ready_i) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        resp_valid_o = (state_q == FULL);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
            id_q   <= '0;
        end else if (accept) begin
            data_q <= mul_res;
            id_q   <= grant_idx;
        end
    end

    assign resp_data_o = data_q;
    assign resp_id_o   = id_q;

endmodule

// File: tb/tb_fpmul_arbiter.sv
// Directed bench for fpmul_arbiter with a queue of expected {id, product} pairs.
module tb_fpmul_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                  clk_i = 1'b0;
    logic                  rst_i;
    logic [NUM_REQ-1:0]    req_valid_i;
    logic [16*NUM_REQ-1:0] req_opA_i;
    logic [16*NUM_REQ-1:0] req_opB_i;
    logic [NUM_REQ-1:0]    req_ready_o;
    logic                  resp_valid_o;
    logic [15:0]           resp_data_o;
    logic [ID_W-1:0]       resp_id_o;
    logic                  resp_ready_i;

    always #5 clk_i = ~clk_i;

    fpmul_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_opA_i    (req_opA_i),
        .req_opB_i    (req_opB_i),
        .req_ready_o  (req_ready_o),
        .resp_valid_o (resp_valid_o),
        .resp_data_o  (resp_data_o),
        .resp_id_o    (resp_id_o),
        .resp_ready_i (resp_ready_i)
    );

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [15:0]     data;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    int          g;
    logic [15:0] prod_tab [NUM_REQ];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic set_lane(input int k, input logic [15:0] a, input logic [15:0] b);
        req_opA_i[16*k +: 16] = a;
        req_opB_i[16*k +: 16] = b;
    endtask

    // One accept cycle: check the grant, queue the expected result, check it next cycle.
    task automatic tick_acc(input int gi, input logic [15:0] prod);
        exp_t e;
        #1;
        chk("grant", 32'(req_ready_o), 32'(1) << gi);
        e.id   = ID_W'(gi);
        e.data = prod;
        sb.push_back(e);
        @(posedge clk_i); #1;
        chk("resp_valid", 32'(resp_valid_o), 32'd1);
        e = sb.pop_front();
        chk("resp_data", 32'(resp_data_o), 32'(e.data));
        chk("resp_id", 32'(resp_id_o), 32'(e.id));
    endtask

    initial begin
        rst_i        = 1'b1;
        req_valid_i  = '1;
        req_opA_i    = '0;
        req_opB_i    = '0;
        resp_ready_i = 1'b0;
        set_lane(0, 16'h4400, 16'h4000);
        @(posedge clk_i); @(posedge clk_i); #1;
        chk("rst_ready", 32'(req_ready_o), 32'd0);
        chk("rst_valid", 32'(resp_valid_o), 32'd0);
        chk("rst_data", 32'(resp_data_o), 32'h0000);
        chk("rst_id", 32'(resp_id_o), 32'd0);

        // First grant after reset goes to lane 0: 4.0 * 2.0 = 8.0
        rst_i        = 1'b0;
        resp_ready_i = 1'b1;
        tick_acc(0, 16'h4800);

        // Back-to-back: 3.0 * 5.0 = 15.0 then 4.0 * 2.0
        set_lane(1, 16'h4200, 16'h4500);
        set_lane(2, 16'h4400, 16'h4000);
        req_valid_i = 4'b0110;
        tick_acc(1, 16'h4B80);
        req_valid_i = 4'b0100;
        tick_acc(2, 16'h4800);

        // Stall for three cycles with a full register
        set_lane(0, 16'h4400, 16'h4200);
        req_valid_i  = 4'b0001;
        resp_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_ready", 32'(req_ready_o), 32'd0);
            @(posedge clk_i); #1;
            chk("stall_valid", 32'(resp_valid_o), 32'd1);
            chk("stall_data", 32'(resp_data_o), 32'h4800);
            chk("stall_id", 32'(resp_id_o), 32'd2);
        end
        resp_ready_i = 1'b1;
        tick_acc(0, 16'h4A00);

        // Drain with nobody requesting: valid clears, data/ID held
        req_valid_i = '0;
        #1;
        chk("drain_ready", 32'(req_ready_o), 32'd0);
        @(posedge clk_i); #1;
        chk("drain_valid", 32'(resp_valid_o), 32'd0);
        chk("drain_data", 32'(resp_data_o), 32'h4A00);
        chk("drain_id", 32'(resp_id_o), 32'd0);

        // Fill from lane 1, then reset while full with every lane requesting
        req_valid_i = 4'b0010;
        tick_acc(1, 16'h4B80);
        rst_i       = 1'b1;
        req_valid_i = 4'b1111;
        #1;
        chk("midrst_ready", 32'(req_ready_o), 32'd0);
        @(posedge clk_i); #1;
        chk("midrst_valid", 32'(resp_valid_o), 32'd0);
        chk("midrst_data", 32'(resp_data_o), 32'h0000);
        chk("midrst_id", 32'(resp_id_o), 32'd0);
        rst_i = 1'b0;

        // Fairness: distinct products per lane (4.0 times 1.0, 2.0, 3.0, 0.5)
        set_lane(0, 16'h4400, 16'h3C00);
        set_lane(1, 16'h4400, 16'h4000);
        set_lane(2, 16'h4400, 16'h4200);
        set_lane(3, 16'h4400, 16'h3800);
        prod_tab[0] = 16'h4400;
        prod_tab[1] = 16'h4800;
        prod_tab[2] = 16'h4A00;
        prod_tab[3] = 16'h4000;
        for (int i = 0; i < 8; i++) begin
`ifdef FPMUL_ARB_RR_EN
            g = i % NUM_REQ;
`else
            g = 0;
`endif
            tick_acc(g, prod_tab[g]);
        end

        req_valid_i = '0;
        @(posedge clk_i); #1;
        chk("final_valid", 32'(resp_valid_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fpmul_arbiter.md
# fpmul_arbiter

Shares one combinational FP16 multiplier (`FPMUL`) among `NUM_REQ` requesters using valid/ready handshakes. Each cycle the block grants at most one request, registers the product with the winner's ID, and holds it until the consumer accepts it. It sits between the lane-level operand sources and the single multiplier instance in the ALU cluster.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `ID_W`, default `$clog2(NUM_REQ)`: requester ID width (derived, do not override).
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `req_valid_i`  in  NUM_REQ  per-requester operand valid.
- `req_opA_i`  in  16*NUM_REQ  FP16 operand A; requester k uses bits [16k+15:16k].
- `req_opB_i`  in  16*NUM_REQ  FP16 operand B; same packing as A.
- `req_ready_o`  out  NUM_REQ  grant; at most one bit is set.
- `resp_valid_o`  out  1  the result register holds a product.
- `resp_data_o`  out  16  FP16 product from `FPMUL`, unmodified.
- `resp_id_o`  out  ID_W  index of the requester that produced `resp_data_o`.
- `resp_ready_i`  in  1  consumer accepts the result.

## Operation
- `can_accept = !resp_valid_o || resp_ready_i`.
- When `can_accept` is set and any `req_valid_i` is set, exactly one `req_ready_o[g]` goes high. It is combinational from `req_valid_i`, the pointer and the response state.
- Requesters must not make `req_valid_i` depend on `req_ready_o`.
- Accept event: `req_valid_i[g] && req_ready_o[g]`. At the clock edge:
  - operands of `g` are muxed into `FPMUL`;
  - the product is written to `resp_data_o` and `g` to `resp_id_o`;
  - `resp_valid_o` is set to 1.
- Drain event: `resp_valid_o && resp_ready_i` with no accept in the same cycle, so `resp_valid_o` clears to 0. Data and ID keep their last values.
- Simultaneous drain and accept: the register is reloaded and `resp_valid_o` stays 1. This gives back-to-back throughput.
- `resp_valid_o && !resp_ready_i` is a stall:
  - every `req_ready_o` is 0;
  - the result register is held stable.
- A requester holds valid and operands stable until granted. A dropped valid is legal and simply not granted.
- Two-state FSM:
  - EMPTY to FULL on accept.
  - FULL stays FULL on accept-with-drain or on stall.
  - FULL to EMPTY on drain without accept.
  - `resp_valid_o` is 1 exactly in FULL.
- Grant pointer `last_q` (ID_W bits) is updated to `g` only on an accept event.

## Timing
- Latency: operands accepted in cycle t give a result with `resp_valid_o` = 1 in cycle t+1.
- Throughput: one product per cycle while `resp_ready_i` = 1.
- Reset values:
  - `resp_valid_o` = 0, `resp_data_o` = 16'h0000, `resp_id_o` = 0;
  - FSM = EMPTY;
  - `last_q` = NUM_REQ-1, so requester 0 has first priority.
- `req_ready_o` is all 0 in any cycle where `rst_i` = 1.
- Reset mid-operation: a pending result is discarded, and an accept in the reset cycle is ignored.
- Single path from `FPMUL` output to the result register. No multicycle paths.

## Configuration
- `FPMUL_ARB_RR_EN` defined: round-robin arbitration.
  - Search starts at `(last_q+1) mod NUM_REQ` and wraps.
  - A continuously requesting lane waits at most NUM_REQ-1 accepts.
- Not defined: fixed priority. The lowest-index valid requester wins and `last_q` is not implemented.
- All other behaviour is identical in both modes.

## Structure
- Package `fpmul_arb_pkg`:
  - `FP16_W` = 16;
  - FSM state enum {EMPTY, FULL};
  - function `rr_pick(valid, last)` returning the granted index.
- Sub-module: the existing `FPMUL` (ports `opA_i`, `opB_i`, `MUL_o`) is instantiated once.
- The arbiter picker stays inline; no further sub-modules.

## Test plan
- Reset: assert `rst_i` with all valids high. Required: `resp_valid_o`=0, `req_ready_o`=0. After release, the first grant goes to requester 0.
- Single product: req0 with A=16'h4400 (4.0), B=16'h4000 (2.0). Required next cycle: `resp_valid_o`=1, `resp_data_o`=16'h4800, `resp_id_o`=0.
- Back-to-back: req1 with 16'h4200 × 16'h4500 and req2 with 16'h4400 × 16'h4000, `resp_ready_i`=1. Required: results 16'h4B80 (id 1) then 16'h4800 (id 2) in consecutive cycles.
- Backpressure: hold `resp_ready_i`=0 for 3 cycles with a full register. Required: `req_ready_o`=0 and data/ID stable. The first cycle with `resp_ready_i`=1 both drains and accepts.
- Fairness (RR_EN): all 4 requesters valid for 8 accepts. Required ID sequence 0,1,2,3,0,1,2,3. Without the macro: 0 on every accept.
- Mid-operation reset: pulse `rst_i` while FULL. Required: `resp_valid_o`=0 next cycle and the pointer returns to its reset value.
